history_mem_ctrl: RTL and testbench
===================================

HISTORY_MEM_CTRL -- requirements
Module: history_mem_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, lines per frame; FIFO_DEPTH, default 4, write-queue entries.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- VGA_VS  in  1  vertical sync; a falling edge starts a frame.
- pixel_tick  in  1  one-cycle pulse requesting the next pixel's history.
- read_addr  out  19  linear address of the presented pixel.
- read_x  out  10  x of the presented pixel.
- read_y  out  10  y of the presented pixel.
- color_history  out  4  stored history for the presented pixel.
- color_valid  out  1  one-cycle strobe that the presented data is valid.
- we  in  1  write-back request.
- write_addr  in  19  write-back address.
- updated_color_history  in  4  write-back data.
- sram_addr  out  19  single-port SRAM address.
- sram_we  out  1  SRAM write enable.
- sram_wdata  out  4  SRAM write data.
- sram_rdata  in  4  SRAM read data, valid 1 cycle after address.
- wr_overflow  out  1  sticky flag: a write was dropped because the queue was full.
- tick_overrun  out  1  sticky flag: a tick was dropped.

Function
REQ-003 SHALL keep scan counters x in 0..H_ACTIVE-1 and y in 0..V_ACTIVE-1, with address y*H_ACTIVE+x.
REQ-004 SHALL advance x on each serviced tick; x SHALL wrap to 0 at H_ACTIVE-1 and increment y; y SHALL wrap to 0 at V_ACTIVE-1.
REQ-005 SHALL detect the VS falling edge from a registered copy of VGA_VS and set x=y=0 on that cycle.
REQ-006 SHALL service a tick coincident with the VS edge at (0,0).
REQ-007 SHALL implement the FSM IDLE -> RD_ISSUE -> RD_CAPTURE -> IDLE, with an additional WR state entered from IDLE.
REQ-008 SHALL behave as follows for a tick at cycle t:
- RD_ISSUE at t+1: drive sram_addr, sram_we=0.
- RD_CAPTURE at t+2: register sram_rdata.
- Present color_history and color_valid=1 at t+3.
- Hold read_addr, read_x and read_y stable from t+3 until the next color_valid.
REQ-009 SHALL give reads priority over writes: IDLE SHALL enter RD_ISSUE when a tick is pending, otherwise WR when the queue is non-empty.
REQ-010 WR SHALL pop one entry, drive sram_we=1 with sram_addr and sram_wdata for exactly one cycle, then return to IDLE.
REQ-011 SHALL hold a tick arriving during a read in a one-deep pending flag; a tick arriving while the flag is already set SHALL be dropped and SHALL set tick_overrun.
REQ-012 SHALL push {write_addr, updated_color_history} whenever we=1 and the queue is not full.
REQ-013 SHALL drop a write when we=1 with the queue full, set wr_overflow, and leave the queue contents unchanged.
REQ-014 SHALL accept a push and a pop in the same cycle at full occupancy, leaving occupancy unchanged with no overflow.
REQ-015 SHALL execute writes in arrival order.
REQ-016 SHALL NOT forward data from read to write; each pixel is read once per frame, so no hazard exists.
REQ-017 SHALL hold sram_we=0 in every state except WR.

Reset
REQ-018 SHALL on reset:
- Clear x, y, the pending flag, the queue, wr_overflow and tick_overrun.
- Force the FSM to IDLE.
- Drive color_valid=0, sram_we=0, and all address and data outputs to 0.
REQ-019 SHALL abort any in-flight read on reset mid-operation with no color_valid, and discard queued writes.

Structure
REQ-020 SHALL place H_ACTIVE, V_ACTIVE, ADDR_W=19, HIST_W=4, FIFO_DEPTH and the FSM state encoding in the shared package vision_pkg.
REQ-021 SHALL implement the write queue as the sub-module history_wr_fifo (synchronous FIFO with full/empty and simultaneous push/pop).

Verification
REQ-022 Single read: SRAM[0]=4'b1011, VS falling edge, tick at t -> sram_addr=0 at t+1; color_valid at t+3 with color_history=4'b1011 and read_x=read_y=0.
REQ-023 Wrap: 640 ticks spaced 4 cycles apart -> the 640th presentation is read_x=0, read_y=1, read_addr=640; the tick at (639,479) is followed by (0,0).
REQ-024 Write back: we=1, write_addr=1234, data=4'b0111, with no ticks pending -> sram_we=1 with that address and data within 2 cycles; a subsequent read of 1234 returns 4'b0111.
REQ-025 Contention and overflow: 5 writes on consecutive cycles while back-to-back ticks hold the FSM in reads -> 4 entries queued; the 5th is dropped and wr_overflow=1; the 4 entries drain in order once ticks stop.
REQ-026 Tick overrun: 3 ticks on consecutive cycles -> 2 color_valid strobes, tick_overrun=1.
REQ-027 Reset: reset asserted at t+2 of a read -> no color_valid, all outputs 0, queue empty, both flags cleared.

Source files
------------

// File: rtl/vision_pkg.sv
// rtl/vision_pkg.sv - shared constants, FSM encoding and write-queue entry type for the history memory controller
package vision_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 19;
    localparam int HIST_W     = 4;
    localparam int X_W        = 10;
    localparam int Y_W        = 10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RD_ISSUE   = 2'd1,
        ST_RD_CAPTURE = 2'd2,
        ST_WR         = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [HIST_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/history_wr_fifo.sv
// rtl/history_wr_fifo.sv - synchronous write-back queue with full/empty and same-cycle push/pop
module history_wr_fifo
    import vision_pkg::*;
#(
    parameter int DEPTH = vision_pkg::FIFO_DEPTH
)(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output wr_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Entry storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/history_mem_ctrl.sv
// rtl/history_mem_ctrl.sv - per-pixel history SRAM arbiter: scan-order reads with queued write-back
module history_mem_ctrl
    import vision_pkg::*;
#(
    parameter int H_ACTIVE   = vision_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = vision_pkg::V_ACTIVE,
    parameter int FIFO_DEPTH = vision_pkg::FIFO_DEPTH
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              VGA_VS,
    input  logic              pixel_tick,
    output logic [ADDR_W-1:0] read_addr,
    output logic [X_W-1:0]    read_x,
    output logic [Y_W-1:0]    read_y,
    output logic [HIST_W-1:0] color_history,
    output logic              color_valid,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [HIST_W-1:0] updated_color_history,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [HIST_W-1:0] sram_wdata,
    input  logic [HIST_W-1:0] sram_rdata,
    output logic              wr_overflow,
    output logic              tick_overrun
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    mem_state_t        state;
    mem_state_t        state_next;
    logic              vs_q;
    logic              vs_fall;
    logic              tick_pending;
    logic [X_W-1:0]    x_cnt;
    logic [Y_W-1:0]    y_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [X_W-1:0]    iss_x;
    logic [Y_W-1:0]    iss_y;
    logic [ADDR_W-1:0] iss_addr;
    wr_entry_t         fifo_din;
    wr_entry_t         fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    assign vs_fall  = vs_q & ~VGA_VS;
    assign fifo_din = '{addr: write_addr, data: updated_color_history};

    history_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (we),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Registered copy of vertical sync for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= VGA_VS;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a waiting tick always beats a queued write
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pixel_tick || tick_pending) begin
                    state_next = ST_RD_ISSUE;
                end else if (!fifo_empty) begin
                    state_next = ST_WR;
                end
            end
            ST_RD_ISSUE:   state_next = ST_RD_CAPTURE;
            ST_RD_CAPTURE: state_next = ST_IDLE;
            ST_WR:         state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: SRAM port is idle (all zero) except while issuing a read or a write
    always_comb begin
        sram_addr  = '0;
        sram_we    = 1'b0;
        sram_wdata = '0;
        fifo_pop   = 1'b0;
        case (state)
            ST_RD_ISSUE: begin
                sram_addr = addr_cnt;
            end
            ST_WR: begin
                sram_addr  = fifo_dout.addr;
                sram_wdata = fifo_dout.data;
                sram_we    = 1'b1;
                fifo_pop   = 1'b1;
            end
            default: begin
                sram_addr = '0;
            end
        endcase
    end

    // Scan position: restarts on VS fall, advances once per serviced tick
    always_ff @(posedge clk) begin
        if (reset || vs_fall) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (state == ST_RD_ISSUE) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                if (y_cnt == Y_LAST) begin
                    y_cnt    <= '0;
                    addr_cnt <= '0;
                end else begin
                    y_cnt    <= y_cnt + 1'b1;
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end else begin
                x_cnt    <= x_cnt + 1'b1;
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

    // Remember which pixel is in flight so the counters can move on
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_x    <= '0;
            iss_y    <= '0;
            iss_addr <= '0;
        end else if (state == ST_RD_ISSUE) begin
            iss_x    <= x_cnt;
            iss_y    <= y_cnt;
            iss_addr <= addr_cnt;
        end
    end

    // Present captured read data; coordinates hold until the next strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            color_valid   <= 1'b0;
            color_history <= '0;
            read_addr     <= '0;
            read_x        <= '0;
            read_y        <= '0;
        end else begin
            color_valid <= (state == ST_RD_CAPTURE);
            if (state == ST_RD_CAPTURE) begin
                color_history <= sram_rdata;
                read_addr     <= iss_addr;
                read_x        <= iss_x;
                read_y        <= iss_y;
            end
        end
    end

    // One-deep tick holding slot; a tick with the slot occupied is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_pending <= 1'b0;
            tick_overrun <= 1'b0;
        end else if (state == ST_IDLE) begin
            // IDLE consumes the held tick first; a fresh tick then takes the slot
            if (tick_pending) begin
                tick_pending <= pixel_tick;
            end
        end else if (pixel_tick) begin
            if (tick_pending) begin
                tick_overrun <= 1'b1;
            end else begin
                tick_pending <= 1'b1;
            end
        end
    end

    // Sticky record of a write-back refused by a full queue
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_overflow <= 1'b0;
        end else if (we && fifo_full && !fifo_pop) begin
            wr_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_history_mem_ctrl.sv
// tb/tb_history_mem_ctrl.sv - self-checking bench for history_mem_ctrl against a scan-order reference model
module tb_history_mem_ctrl;

    localparam int H     = 640;
    localparam int V     = 4;
    localparam int FRAME = H * V;

    logic        clk = 1'b0;
    logic        reset;
    logic        VGA_VS;
    logic        pixel_tick;
    logic [18:0] read_addr;
    logic [9:0]  read_x;
    logic [9:0]  read_y;
    logic [3:0]  color_history;
    logic        color_valid;
    logic        we;
    logic [18:0] write_addr;
    logic [3:0]  updated_color_history;
    logic [18:0] sram_addr;
    logic        sram_we;
    logic [3:0]  sram_wdata;
    logic [3:0]  sram_rdata;
    logic        wr_overflow;
    logic        tick_overrun;

    always #5 clk = ~clk;

    history_mem_ctrl #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .VGA_VS                (VGA_VS),
        .pixel_tick            (pixel_tick),
        .read_addr             (read_addr),
        .read_x                (read_x),
        .read_y                (read_y),
        .color_history         (color_history),
        .color_valid           (color_valid),
        .we                    (we),
        .write_addr            (write_addr),
        .updated_color_history (updated_color_history),
        .sram_addr             (sram_addr),
        .sram_we               (sram_we),
        .sram_wdata            (sram_wdata),
        .sram_rdata            (sram_rdata),
        .wr_overflow           (wr_overflow),
        .tick_overrun          (tick_overrun)
    );

    int total = 0;
    int bad   = 0;

    int          exp_q [$];
    logic [22:0] wq [$];
    logic [3:0]  ovr_data  [0:4095];
    logic        ovr_valid [0:4095];
    int          pos;
    int          n_valid = 0;
    int          n_wr    = 0;
    int          last_x  = -1;
    int          last_y  = -1;
    int          last_addr = -1;

    function automatic logic [3:0] init_val(input int a);
        logic [31:0] v;
        if (a == 0) return 4'b1011;
        v = (a * 13) ^ (a >> 3) ^ 5;
        return v[3:0];
    endfunction

    function automatic logic [3:0] exp_color(input int a);
        if (ovr_valid[a]) return ovr_data[a];
        return init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Single-port SRAM model with one-cycle registered read
    initial begin
        logic [3:0] mem [0:4095];
        for (int i = 0; i < 4096; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            sram_rdata <= mem[sram_addr[11:0]];
            if (sram_we) mem[sram_addr[11:0]] <= sram_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        int          e;
        logic [22:0] w;
        forever begin
            @(negedge clk);
            if (color_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_x", read_x, e % H);
                    check("read_y", read_y, e / H);
                    check("read_addr", read_addr, e);
                    check("color", color_history, exp_color(e));
                    last_x = read_x;
                    last_y = read_y;
                    last_addr = read_addr;
                end
            end
            if (sram_we) begin
                n_wr++;
                if (wq.size() == 0) begin
                    check("spurious_write", 32'd1, 32'd0);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", sram_addr, w[22:4]);
                    check("wr_data", sram_wdata, w[3:0]);
                end
            end
        end
    endtask

    task automatic do_tick(input int gap);
        pixel_tick = 1'b1;
        exp_q.push_back(pos);
        pos = (pos + 1) % FRAME;
        step();
        pixel_tick = 1'b0;
        repeat (gap - 1) step();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || wq.size() != 0) && n < 200) begin
            step();
            n++;
        end
        repeat (4) step();
        check(tag, exp_q.size() + wq.size(), 0);
    endtask

    task automatic check_outputs_zero();
        check("rst_valid", color_valid, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_read_addr", read_addr, 0);
        check("rst_read_x", read_x, 0);
        check("rst_read_y", read_y, 0);
        check("rst_color", color_history, 0);
        check("rst_wr_overflow", wr_overflow, 0);
        check("rst_tick_overrun", tick_overrun, 0);
    endtask

    initial begin
        int          n0;
        int          w0;
        int          found;
        int          a;
        logic [3:0]  d;
        logic [22:0] ent;

        for (int i = 0; i < 4096; i++) ovr_valid[i] = 1'b0;
        reset = 1'b1;
        VGA_VS = 1'b0;
        pixel_tick = 1'b0;
        we = 1'b0;
        write_addr = '0;
        updated_color_history = '0;
        pos = 0;
        fork
            monitor();
        join_none

        repeat (3) step();
        check_outputs_zero();
        reset = 1'b0;
        step();

        // Single read with tick coincident with VS fall
        VGA_VS = 1'b1;
        repeat (3) step();
        VGA_VS = 1'b0;
        pixel_tick = 1'b1;
        exp_q.push_back(0);
        pos = 1;
        step();
        pixel_tick = 1'b0;
        check("t1_sram_addr", sram_addr, 0);
        check("t1_sram_we", sram_we, 0);
        step();
        check("t2_valid", color_valid, 0);
        step();
        check("t3_valid", color_valid, 1);
        check("t3_color", color_history, 4'b1011);
        check("t3_x", read_x, 0);
        check("t3_y", read_y, 0);
        repeat (3) step();

        // 640 ticks at 4-cycle spacing: wraps onto the next line
        for (int i = 0; i < 640; i++) do_tick(4);
        check("wrap_x", last_x, 0);
        check("wrap_y", last_y, 1);
        check("wrap_addr", last_addr, 640);

        // Write-back with nothing else pending
        ovr_data[1234] = 4'b0111;
        ovr_valid[1234] = 1'b1;
        ent = {19'd1234, 4'b0111};
        wq.push_back(ent);
        we = 1'b1;
        write_addr = 19'd1234;
        updated_color_history = 4'b0111;
        step();
        we = 1'b0;
        found = 0;
        for (int i = 0; i < 2; i++) begin
            if (sram_we && sram_addr == 19'd1234 && sram_wdata == 4'b0111) found = 1;
            step();
        end
        check("wb_within_2", found, 1);
        drain("wb_drain");

        // Random spacing with sparse write-backs ahead of the scan, to end of frame
        while (pos != 0) begin
            if ($urandom_range(0, 3) == 0 && wq.size() < 2 && pos + 200 < FRAME) begin
                a = $urandom_range(pos + 200, FRAME - 1);
                if (a == 1234) a = 1235;
                d = 4'($urandom);
                ovr_data[a] = d;
                ovr_valid[a] = 1'b1;
                ent = {19'(a), d};
                wq.push_back(ent);
                we = 1'b1;
                write_addr = 19'(a);
                updated_color_history = d;
                step();
                we = 1'b0;
                repeat (3) step();
            end
            do_tick($urandom_range(4, 6));
        end
        drain("frame_drain");
        check("frame_end_x", last_x, 639);
        check("frame_end_y", last_y, V - 1);
        do_tick(4);
        drain("frame_wrap_drain");
        check("frame_wrap_x", last_x, 0);
        check("frame_wrap_y", last_y, 0);
        check("frame_wrap_addr", last_addr, 0);

        // Five writes while ticks keep the FSM reading: fifth is dropped
        w0 = n_wr;
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 0) begin
                pixel_tick = 1'b1;
                exp_q.push_back(pos);
                pos = (pos + 1) % FRAME;
            end else begin
                pixel_tick = 1'b0;
            end
            if (i < 5) begin
                d = 4'($urandom);
                we = 1'b1;
                write_addr = 19'(3000 + i);
                updated_color_history = d;
                if (i < 4) begin
                    ent = {19'(3000 + i), d};
                    wq.push_back(ent);
                end
            end else begin
                we = 1'b0;
            end
            if (i == 4) check("ovf_before", wr_overflow, 0);
            step();
            if (i == 4) check("ovf_after", wr_overflow, 1);
        end
        pixel_tick = 1'b0;
        check("no_write_during_reads", n_wr - w0, 0);
        drain("ovf_drain");
        check("ovf_drained_count", n_wr - w0, 4);
        check("ovf_sticky", wr_overflow, 1);

        // Three back-to-back ticks: two strobes and an overrun
        check("overrun_before", tick_overrun, 0);
        n0 = n_valid;
        exp_q.push_back(pos);
        exp_q.push_back((pos + 1) % FRAME);
        pos = (pos + 2) % FRAME;
        pixel_tick = 1'b1;
        repeat (3) step();
        pixel_tick = 1'b0;
        repeat (10) step();
        check("overrun_strobes", n_valid - n0, 2);
        check("overrun_flag", tick_overrun, 1);
        drain("overrun_drain");

        // Reset in the capture cycle of a read, with a write queued behind it
        pixel_tick = 1'b1;
        step();
        pixel_tick = 1'b0;
        we = 1'b1;
        write_addr = 19'd3100;
        updated_color_history = 4'd5;
        step();
        we = 1'b0;
        reset = 1'b1;
        n0 = n_valid;
        w0 = n_wr;
        step();
        check_outputs_zero();
        reset = 1'b0;
        pos = 0;
        repeat (8) step();
        check("rst_no_valid", n_valid - n0, 0);
        check("rst_no_write", n_wr - w0, 0);
        do_tick(4);
        drain("post_rst_drain");
        check("post_rst_addr", last_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
